// File: rtl/unified_mem_responder_if.sv
// Request/response bundle between the RV32 core's fetch and load/store ports and
// the unified memory responder.
interface unified_mem_responder_if #(
    parameter int unsigned ADDR_W = 8
) ();
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [2:0]        d_func3;
    logic              d_ready;
    logic [31:0]       d_rdata;
    logic              d_err;

    modport master (
        output if_req, if_addr,
        input  if_ready, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_func3,
        input  d_ready, d_rdata, d_err
    );

    modport slave (
        input  if_req, if_addr,
        output if_ready, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_func3,
        output d_ready, d_rdata, d_err
    );
endinterface

// File: rtl/unified_mem_responder.sv
// Single-port little-endian word array shared by instruction fetch and data access,
// serving one request at a time with RV32 load/store width and sign handling.
module unified_mem_responder #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned READ_WAIT = 1
) (
    input logic                     clk,
    input logic                     rst,
    unified_mem_responder_if.slave  bus
);
    localparam int unsigned WORDS = 2 ** (ADDR_W - 2);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_next;

    // Latched copy of the captured request.
    logic              r_is_data;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [2:0]        r_func3;

    logic              r_if_ready;
    logic [31:0]       r_if_rdata;
    logic              r_d_ready;
    logic [31:0]       r_d_rdata;
    logic              r_d_err;

    logic              w_if_ready_next;
    logic [31:0]       w_if_rdata_next;
    logic              w_d_ready_next;
    logic [31:0]       w_d_rdata_next;
    logic              w_d_err_next;

    logic              w_capture;
    logic              w_cap_data;
    logic              w_mem_we;

    logic [31:0]       r_mem [WORDS];

    logic [31:0]       w_word;
    logic [31:0]       w_shift;
    logic [15:0]       w_half;
    logic              w_err;
    logic [31:0]       w_load;
    logic [31:0]       w_wr_word;

    // Access decode for the latched request.
    always_comb begin
        w_word    = r_mem[r_addr[ADDR_W-1:2]];
        w_shift   = w_word >> {r_addr[1:0], 3'b000};
        w_half    = r_addr[1] ? w_word[31:16] : w_word[15:0];
        w_err     = 1'b0;
        w_load    = 32'h0;
        w_wr_word = w_word;
        if (r_we) begin
            unique case (r_func3)
                3'b000: w_wr_word[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
                3'b001: begin
                    w_err = r_addr[0];
                    w_wr_word[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
                end
                3'b010: begin
                    w_err     = (r_addr[1:0] != 2'b00);
                    w_wr_word = r_wdata;
                end
                default: w_err = 1'b1;
            endcase
        end else begin
            unique case (r_func3)
                3'b000: w_load = {{24{w_shift[7]}}, w_shift[7:0]};
                3'b100: w_load = {24'h0, w_shift[7:0]};
                3'b001: begin
                    w_err  = r_addr[0];
                    w_load = {{16{w_half[15]}}, w_half};
                end
                3'b101: begin
                    w_err  = r_addr[0];
                    w_load = {16'h0, w_half};
                end
                3'b010: begin
                    w_err  = (r_addr[1:0] != 2'b00);
                    w_load = w_word;
                end
                default: w_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_capture       = 1'b0;
        w_cap_data      = 1'b0;
        w_mem_we        = 1'b0;
        w_if_ready_next = 1'b0;
        w_if_rdata_next = 32'h0;
        w_d_ready_next  = 1'b0;
        w_d_rdata_next  = 32'h0;
        w_d_err_next    = 1'b0;
        unique case (r_state)
            StIdle: begin
                // Data wins a tie: it belongs to the older instruction in the pipe.
                if (bus.d_req) begin
                    w_capture    = 1'b1;
                    w_cap_data   = 1'b1;
                    w_cnt_next   = 4'(READ_WAIT);
                    w_state_next = StBusy;
                end else if (bus.if_req) begin
                    w_capture    = 1'b1;
                    w_cnt_next   = 4'(READ_WAIT);
                    w_state_next = StBusy;
                end
            end
            StBusy: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_next = r_cnt - 4'd1;
                end else begin
                    w_state_next = StResp;
                    if (r_is_data) begin
                        w_d_ready_next = 1'b1;
                        w_d_err_next   = w_err;
                        w_d_rdata_next = (w_err || r_we) ? 32'h0 : w_load;
                        w_mem_we       = r_we && !w_err;
                    end else begin
                        w_if_ready_next = 1'b1;
                        w_if_rdata_next = w_word;
                    end
                end
            end
            StResp: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cnt      <= 4'd0;
            r_if_ready <= 1'b0;
            r_if_rdata <= 32'h0;
            r_d_ready  <= 1'b0;
            r_d_rdata  <= 32'h0;
            r_d_err    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_if_ready <= w_if_ready_next;
            r_if_rdata <= w_if_rdata_next;
            r_d_ready  <= w_d_ready_next;
            r_d_rdata  <= w_d_rdata_next;
            r_d_err    <= w_d_err_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_is_data <= w_cap_data;
            r_we      <= w_cap_data && bus.d_we;
            r_addr    <= w_cap_data ? bus.d_addr : bus.if_addr;
            r_wdata   <= bus.d_wdata;
            r_func3   <= bus.d_func3;
        end
    end

    // Reset aborts a store that would otherwise commit on this edge.
    always_ff @(posedge clk) begin
        if (!rst && w_mem_we) begin
            r_mem[r_addr[ADDR_W-1:2]] <= w_wr_word;
        end
    end

    assign bus.if_ready = r_if_ready;
    assign bus.if_rdata = r_if_rdata;
    assign bus.d_ready  = r_d_ready;
    assign bus.d_rdata  = r_d_rdata;
    assign bus.d_err    = r_d_err;
endmodule

// File: tb/tb_unified_mem_responder.sv
// Directed and randomized checks of unified_mem_responder against a byte-array model.
module tb_unified_mem_responder;
    localparam int unsigned AW = 8;
    localparam int unsigned RW = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    unified_mem_responder_if #(.ADDR_W(AW)) bus ();

    unified_mem_responder #(.ADDR_W(AW), .READ_WAIT(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [7:0] model_mem [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
        end
    endtask

    // Byte-level model of an RV32 load/store on the little-endian array.
    function automatic void model(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                                  input logic [2:0] f3, output logic [31:0] rdata,
                                  output logic err);
        int size;
        logic [31:0] v;
        logic [7:0] b;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
        err   = (size == 0) || (we && f3[2]) || (!we && f3 == 3'b110);
        if (!err && (int'(addr) % size) != 0) err = 1'b1;
        rdata = 32'h0;
        if (!err) begin
            v = 32'h0;
            for (int i = 0; i < size; i++) begin
                b = addr + 8'(i);
                if (we) model_mem[b] = wdata[8*i +: 8];
                else    v[8*i +: 8] = model_mem[b];
            end
            if (!we) begin
                if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
                rdata = v;
            end
        end
    endfunction

    task automatic data_op(input string tag, input logic we, input logic [7:0] addr,
                           input logic [31:0] wdata, input logic [2:0] f3,
                           output logic [31:0] got, output logic got_err);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          n;
        model(we, addr, wdata, f3, exp_rd, exp_err);
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        bus.d_func3 = f3;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.d_ready !== 1'b1 && n < 40);
        check({tag, " latency"}, n, RW + 2);
        check1({tag, " d_ready"}, bus.d_ready, 1'b1);
        check1({tag, " d_err"}, bus.d_err, exp_err);
        check({tag, " d_rdata"}, bus.d_rdata, exp_rd);
        check1({tag, " if_ready idle"}, bus.if_ready, 1'b0);
        got     = bus.d_rdata;
        got_err = bus.d_err;
        bus.d_req = 1'b0;
        @(posedge clk);
        #1;
        check1({tag, " d_ready drop"}, bus.d_ready, 1'b0);
        check({tag, " d_rdata clear"}, bus.d_rdata, 32'h0);
    endtask

    task automatic fetch_op(input string tag, input logic [7:0] addr, output logic [31:0] got);
        logic [31:0] exp_w;
        logic [7:0]  base;
        int          n;
        base  = {addr[7:2], 2'b00};
        exp_w = {model_mem[base + 8'd3], model_mem[base + 8'd2],
                 model_mem[base + 8'd1], model_mem[base]};
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.if_ready !== 1'b1 && n < 40);
        check({tag, " latency"}, n, RW + 2);
        check1({tag, " if_ready"}, bus.if_ready, 1'b1);
        check({tag, " if_rdata"}, bus.if_rdata, exp_w);
        check1({tag, " d_ready idle"}, bus.d_ready, 1'b0);
        check({tag, " d_rdata idle"}, bus.d_rdata, 32'h0);
        got = bus.if_rdata;
        bus.if_req = 1'b0;
        @(posedge clk);
        #1;
        check1({tag, " if_ready drop"}, bus.if_ready, 1'b0);
        check({tag, " if_rdata clear"}, bus.if_rdata, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [7:0]  a;
        int          dc;
        int          ic;
        int          c;

        rst         = 1'b1;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_func3 = '0;
        repeat (3) @(posedge clk);
        #1;
        check1("reset if_ready", bus.if_ready, 1'b0);
        check("reset if_rdata", bus.if_rdata, 32'h0);
        check1("reset d_ready", bus.d_ready, 1'b0);
        check("reset d_rdata", bus.d_rdata, 32'h0);
        check1("reset d_err", bus.d_err, 1'b0);
        rst = 1'b0;

        for (int w = 0; w < 64; w++) begin
            data_op("init sw", 1'b1, 8'(w * 4), $urandom, 3'b010, rd, er);
        end

        // Test plan 1..3
        data_op("t1 sw", 1'b1, 8'h10, 32'hDEADBEEF, 3'b010, rd, er);
        data_op("t1 lw", 1'b0, 8'h10, 32'h0, 3'b010, rd, er);
        check("t1 lw value", rd, 32'hDEADBEEF);
        check1("t1 lw err", er, 1'b0);
        data_op("t2 lb", 1'b0, 8'h13, 32'h0, 3'b000, rd, er);
        check("t2 lb value", rd, 32'hFFFFFFDE);
        data_op("t2 lbu", 1'b0, 8'h13, 32'h0, 3'b100, rd, er);
        check("t2 lbu value", rd, 32'h000000DE);
        data_op("t2 lh", 1'b0, 8'h12, 32'h0, 3'b001, rd, er);
        check("t2 lh value", rd, 32'hFFFFDEAD);
        data_op("t2 lhu", 1'b0, 8'h12, 32'h0, 3'b101, rd, er);
        check("t2 lhu value", rd, 32'h0000DEAD);
        data_op("t2 lb0", 1'b0, 8'h10, 32'h0, 3'b000, rd, er);
        check("t2 lb0 value", rd, 32'hFFFFFFEF);
        data_op("t3 sb", 1'b1, 8'h11, 32'h00000055, 3'b000, rd, er);
        data_op("t3 lw a", 1'b0, 8'h10, 32'h0, 3'b010, rd, er);
        check("t3 sb result", rd, 32'hDEAD55EF);
        data_op("t3 sh", 1'b1, 8'h12, 32'h00001234, 3'b001, rd, er);
        data_op("t3 lw b", 1'b0, 8'h10, 32'h0, 3'b010, rd, er);
        check("t3 sh result", rd, 32'h123455EF);

        // Test plan 4: simultaneous fetch and data, data served first
        bus.if_req  = 1'b1;
        bus.if_addr = 8'h00;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 8'h10;
        bus.d_func3 = 3'b010;
        dc = 0;
        ic = 0;
        c  = 0;
        while ((dc == 0 || ic == 0) && c < 60) begin
            @(posedge clk);
            #1;
            c++;
            if (bus.d_ready === 1'b1) begin
                dc = c;
                check("t4 d_rdata", bus.d_rdata, 32'h123455EF);
                check1("t4 if_ready during d", bus.if_ready, 1'b0);
                bus.d_req = 1'b0;
            end
            if (bus.if_ready === 1'b1) begin
                ic = c;
                check("t4 if_rdata", bus.if_rdata,
                      {model_mem[3], model_mem[2], model_mem[1], model_mem[0]});
                check1("t4 d_ready during if", bus.d_ready, 1'b0);
                bus.if_req = 1'b0;
            end
        end
        check("t4 d latency", dc, RW + 2);
        check("t4 if after d", ic - dc, RW + 3);
        @(posedge clk);
        #1;

        // Test plan 5: misaligned and illegal accesses
        data_op("t5 lw mis", 1'b0, 8'h12, 32'h0, 3'b010, rd, er);
        check1("t5 lw mis err", er, 1'b1);
        check("t5 lw mis data", rd, 32'h0);
        data_op("t5 sw mis", 1'b1, 8'h11, 32'hFFFFFFFF, 3'b010, rd, er);
        check1("t5 sw mis err", er, 1'b1);
        data_op("t5 lw after", 1'b0, 8'h10, 32'h0, 3'b010, rd, er);
        check("t5 lw unchanged", rd, 32'h123455EF);
        data_op("t5 f3 011", 1'b0, 8'h10, 32'h0, 3'b011, rd, er);
        check1("t5 f3 011 err", er, 1'b1);

        // Test plan 6: reset on the would-be commit edge of a store
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 8'h20;
        bus.d_wdata = 32'hAAAAAAAA;
        bus.d_func3 = 3'b010;
        @(posedge clk);
        #1;
        repeat (RW) begin
            @(posedge clk);
            #1;
        end
        rst       = 1'b1;
        bus.d_req = 1'b0;
        @(posedge clk);
        #1;
        check1("t6 no d_ready", bus.d_ready, 1'b0);
        check("t6 d_rdata", bus.d_rdata, 32'h0);
        check1("t6 d_err", bus.d_err, 1'b0);
        check1("t6 if_ready", bus.if_ready, 1'b0);
        rst = 1'b0;
        repeat (RW + 3) begin
            @(posedge clk);
            #1;
            check1("t6 quiet", bus.d_ready, 1'b0);
        end
        data_op("t6 lw old", 1'b0, 8'h20, 32'h0, 3'b010, rd, er);

        // Randomized mix against the model
        for (int k = 0; k < 200; k++) begin
            a = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            if ($urandom_range(0, 9) < 2) begin
                fetch_op("rnd fetch", a, rd);
            end else begin
                data_op("rnd data", 1'($urandom_range(0, 1)), a, $urandom,
                        3'($urandom_range(0, 7)), rd, er);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/unified_mem_responder.md
Name: unified_mem_responder

Overview:
- Memory-side responder for the pipelined RV32 core's fetch and load/store ports.
- Owns a single-port, byte-addressable, little-endian 32-bit-word array shared by instruction fetch and data access.
- Arbitrates between the two request ports and serves one access at a time through a req/ready handshake.
- Applies RV32 func3 width and sign rules to data loads and stores.

Parameters:
- ADDR_W, 8: byte-address width; array size is 2^ADDR_W bytes.
- READ_WAIT, 1: extra wait cycles between request capture and response (0..15).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- if_req  input  1  instruction fetch request; held until if_ready.
- if_addr  input  ADDR_W  fetch byte address; bits [1:0] ignored (word-aligned fetch).
- if_ready  output  1  one-cycle pulse; if_rdata valid while high.
- if_rdata  output  32  fetched instruction word.
- d_req  input  1  data request; held, with all d_* inputs stable, until d_ready.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  ADDR_W  data byte address.
- d_wdata  input  32  store data; low byte/half used for SB/SH.
- d_func3  input  3  RV32 load/store funct3.
- d_ready  output  1  one-cycle completion pulse for a load or store.
- d_rdata  output  32  load result, extended per func3; 0 for stores and errors.
- d_err  output  1  high with d_ready when the access was rejected.

Behaviour:
- Reset: state=IDLE, wait counter=0. All outputs are 0 (if_ready, if_rdata, d_ready, d_rdata, d_err). Array contents are not cleared.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If d_req, capture the data request. Data has priority on a tie: it belongs to the older instruction.
  - Otherwise, if if_req, capture the fetch request.
  - Capture sets cnt=READ_WAIT and moves to BUSY. If no request is present, stay in IDLE.
- BUSY:
  - If cnt!=0: decrement cnt.
  - Else: perform the access, register the outputs, raise the matching ready, go to RESP.
- RESP:
  - Ready is high for exactly this cycle; then go to IDLE.
  - No request is sampled in RESP, so a requester that drops req on the edge after ready is never double-served.
- Latency: ready rises READ_WAIT+1 rising edges after the capture edge.
- Throughput: one access per READ_WAIT+3 cycles.
- A captured request is served from its latched copy; input changes after capture are ignored.
- Loads (rdata assembled from the word at addr[ADDR_W-1:2]):
  - LB (000): byte addr[1:0], sign-extended.
  - LBU (100): byte addr[1:0], zero-extended.
  - LH (001): half addr[1], sign-extended.
  - LHU (101): half addr[1], zero-extended.
  - LW (010): full word.
- Stores (write commits on the same edge that raises d_ready; other bytes unchanged):
  - SB (000): byte lane addr[1:0].
  - SH (001): half lane addr[1].
  - SW (010): full word.
- Errors (d_err=1, d_rdata=0, no array write, normal latency):
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Load func3 011, 110 or 111.
  - Store func3 other than 000, 001 or 010.
- Fetch: always a word read; never produces an error.
- Addresses wrap modulo 2^ADDR_W; there is no out-of-range condition.
- Outputs of the port not being served stay 0.
- rdata holds its value only during the ready cycle; it returns to 0 in IDLE.
- rst in any state:
  - Aborts the pending access; a store in BUSY is not committed.
  - No ready pulse is produced.
  - Return to IDLE next cycle.
- rst has priority over all requests.

Test Plan:
1. rst, then SW 0xDEADBEEF @0x10, then LW @0x10 (READ_WAIT=1) -> each d_ready rises 2 edges after capture, pulses 1 cycle; LW returns d_rdata=0xDEADBEEF, d_err=0.
2. With the word from test 1, loads -> LB @0x13 = 0xFFFFFFDE; LBU @0x13 = 0x000000DE; LH @0x12 = 0xFFFFDEAD; LHU @0x12 = 0x0000DEAD; LB @0x10 = 0xFFFFFFEF.
3. SB 0x00000055 @0x11 then LW @0x10 -> 0xDEAD55EF. SH 0x00001234 @0x12 then LW @0x10 -> 0x123455EF.
4. if_req @0x00 and d_req LW @0x10 raised in the same cycle -> d_ready pulses first. if_ready pulses READ_WAIT+3 cycles later, with if_rdata = word @0x00.
5. LW @0x12 -> d_ready=1, d_err=1, d_rdata=0. SW 0xFFFFFFFF @0x11 -> d_err=1; a following LW @0x10 is unchanged. Load func3=011 -> d_err=1.
6. rst pulsed while a SW 0xAAAAAAAA @0x20 is in BUSY -> no d_ready, all outputs 0. A later LW @0x20 returns the old value.
